rvfi_trace_buffer: RTL and testbench

- Parametrised capture buffer for RVFI retirement packets; successor to the single-lane, print-only tracer hookup.
- Accepts up to NRET retired instructions per cycle from the core's WB-stage RVFI signals.
- Stores them in a circular buffer with stop-on-full or wrap (keep-newest) mode, plus an optional PC trigger.
- Drains records through a valid/ready port to a debug reader (UART dumper or bench monitor).

---
 rtl/rvfi_trace_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_rvfi_trace_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement capture buffer: NRET lanes in, circular store, valid/ready drain.
// Optional RVFI_TRACE_TS_EN adds a per-record cycle timestamp on out_ts_o.
module rvfi_trace_buffer #(
    parameter int unsigned NRET  = 1,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NRET-1:0]        rvfi_valid_i,
    input  logic [32*NRET-1:0]     rvfi_pc_rdata_i,
    input  logic [32*NRET-1:0]     rvfi_insn_i,
    input  logic [5*NRET-1:0]      rvfi_rd_addr_i,
    input  logic [32*NRET-1:0]     rvfi_rd_wdata_i,
    input  logic                   arm_i,
    input  logic                   cfg_wrap_i,
    input  logic                   cfg_trig_en_i,
    input  logic [31:0]            cfg_trig_pc_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [31:0]            out_pc_o,
    output logic [31:0]            out_insn_o,
    output logic [4:0]             out_rd_addr_o,
    output logic [31:0]            out_rd_wdata_o,
    output logic [CW-1:0]          count_o,
    output logic [15:0]            dropped_o,
    output logic                   overflow_o,
    output logic [1:0]             state_o
`ifdef RVFI_TRACE_TS_EN
    ,
    output logic [31:0]            out_ts_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_STOPPED = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
`ifdef RVFI_TRACE_TS_EN
        logic [31:0] ts;
`endif
    } rec_t;

    rec_t           mem [DEPTH];
    rec_t           lane_rec [NRET];
    rec_t           rd_rec;
    state_e         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [15:0]    dropped_q;
    logic           overflow_q;

    logic [NRET-1:0] cand;
    logic            found;
    logic            pop;
    logic            stop_hit;
    logic [SW-1:0]   n_cand, n_valid, n_wr, n_drop, free, level, excess, k;
    logic [NRET-1:0] wr_en;
    logic [AW-1:0]   wr_idx [NRET];
    logic [16:0]     drop_sum;
    logic [15:0]     dropped_d;

`ifdef RVFI_TRACE_TS_EN
    logic [31:0] ts_q;

    // Free-running timestamp; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ts_q <= '0;
        else         ts_q <= ts_q + 32'd1;
    end
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (arm_i) begin
            state_d = cfg_trig_en_i ? S_ARMED : S_CAPTURE;
        end else begin
            case (state_q)
                S_ARMED:   if (|cand)    state_d = S_CAPTURE;
                S_CAPTURE: if (stop_hit) state_d = S_STOPPED;
                default:   state_d = state_q;
            endcase
        end
    end

    // Lane selection, slot allocation and occupancy arithmetic
    always_comb begin
        cand    = '0;
        found   = 1'b0;
        n_cand  = '0;
        n_valid = '0;
        k       = '0;
        wr_en   = '0;
        for (int i = 0; i < NRET; i++) begin
            wr_idx[i]   = wr_ptr_q;
            lane_rec[i] = '0;
        end
        if (!arm_i) begin
            if (state_q == S_CAPTURE) begin
                cand = rvfi_valid_i;
            end else if (state_q == S_ARMED) begin
                // Lowest matching lane opens the window; later valid lanes follow it.
                for (int i = 0; i < NRET; i++) begin
                    if (rvfi_valid_i[i] && (found || rvfi_pc_rdata_i[32*i +: 32] == cfg_trig_pc_i)) begin
                        cand[i] = 1'b1;
                        found   = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < NRET; i++) begin
            n_cand  = n_cand + SW'(cand[i]);
            n_valid = n_valid + SW'(rvfi_valid_i[i]);
        end
        pop  = (count_q != '0) && out_ready_i;
        free = SW'(DEPTH) - SW'(count_q);
        n_wr = (cfg_wrap_i || n_cand <= free) ? n_cand : free;
        stop_hit = n_cand > n_wr;
        n_drop = (state_q == S_STOPPED && !arm_i) ? n_valid : (n_cand - n_wr);
        level  = SW'(count_q) - SW'(pop) + n_wr;
        excess = (level > SW'(DEPTH)) ? (level - SW'(DEPTH)) : '0;
        for (int i = 0; i < NRET; i++) begin
            lane_rec[i].pc       = rvfi_pc_rdata_i[32*i +: 32];
            lane_rec[i].insn     = rvfi_insn_i[32*i +: 32];
            lane_rec[i].rd_addr  = rvfi_rd_addr_i[5*i +: 5];
            lane_rec[i].rd_wdata = rvfi_rd_wdata_i[32*i +: 32];
`ifdef RVFI_TRACE_TS_EN
            lane_rec[i].ts       = ts_q;
`endif
            wr_idx[i] = wr_ptr_q + AW'(k);
            if (cand[i] && k < n_wr) begin
                wr_en[i] = 1'b1;
                k        = k + SW'(1);
            end
        end
        drop_sum  = 17'(dropped_q) + 17'(n_drop);
        dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Pointers, occupancy and statistics
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else if (arm_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_q + AW'(n_wr);
            rd_ptr_q   <= rd_ptr_q + AW'(SW'(pop) + excess);
            count_q    <= CW'(level - excess);
            dropped_q  <= dropped_d;
            overflow_q <= overflow_q | (excess != '0);
        end
    end

    // Record storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < NRET; i++) begin
                if (wr_en[i]) mem[wr_idx[i]] <= lane_rec[i];
            end
        end
    end

    assign rd_rec         = mem[rd_ptr_q];
    assign out_valid_o    = (count_q != '0);
    assign out_pc_o       = rd_rec.pc;
    assign out_insn_o     = rd_rec.insn;
    assign out_rd_addr_o  = rd_rec.rd_addr;
    assign out_rd_wdata_o = rd_rec.rd_wdata;
    assign count_o        = count_q;
    assign dropped_o      = dropped_q;
    assign overflow_o     = overflow_q;
    assign state_o        = state_q;
`ifdef RVFI_TRACE_TS_EN
    assign out_ts_o       = rd_rec.ts;
`endif

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Directed bench for rvfi_trace_buffer (NRET=2, DEPTH=4); inputs driven and outputs sampled at negedge.
module tb_rvfi_trace_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  rvfi_valid_i;
    logic [63:0] rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_wdata_i;
    logic [9:0]  rvfi_rd_addr_i;
    logic        arm_i, cfg_wrap_i, cfg_trig_en_i;
    logic [31:0] cfg_trig_pc_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] out_pc_o, out_insn_o, out_rd_wdata_o;
    logic [4:0]  out_rd_addr_o;
    logic [2:0]  count_o;
    logic [15:0] dropped_o;
    logic        overflow_o;
    logic [1:0]  state_o;
`ifdef RVFI_TRACE_TS_EN
    logic [31:0] out_ts_o;
`endif

    int checks = 0;
    int errors = 0;

    rvfi_trace_buffer #(.NRET(2), .DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rvfi_valid_i(rvfi_valid_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i),
        .rvfi_insn_i(rvfi_insn_i), .rvfi_rd_addr_i(rvfi_rd_addr_i),
        .rvfi_rd_wdata_i(rvfi_rd_wdata_i),
        .arm_i(arm_i), .cfg_wrap_i(cfg_wrap_i), .cfg_trig_en_i(cfg_trig_en_i),
        .cfg_trig_pc_i(cfg_trig_pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_insn_o(out_insn_o),
        .out_rd_addr_o(out_rd_addr_o), .out_rd_wdata_o(out_rd_wdata_o),
        .count_o(count_o), .dropped_o(dropped_o), .overflow_o(overflow_o),
        .state_o(state_o)
`ifdef RVFI_TRACE_TS_EN
        , .out_ts_o(out_ts_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle of retirement; payload fields are derived from the PC.
    task automatic retire(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
        rvfi_valid_i    = v;
        rvfi_pc_rdata_i = {p1, p0};
        rvfi_insn_i     = {~p1, ~p0};
        rvfi_rd_addr_i  = {p1[6:2], p0[6:2]};
        rvfi_rd_wdata_i = {p1 ^ 32'h5A5A0000, p0 ^ 32'h5A5A0000};
        @(negedge clk_i);
        rvfi_valid_i    = 2'b00;
    endtask

    task automatic arm(input logic wrap, input logic trig, input logic [31:0] tpc);
        cfg_wrap_i    = wrap;
        cfg_trig_en_i = trig;
        cfg_trig_pc_i = tpc;
        arm_i         = 1'b1;
        @(negedge clk_i);
        arm_i         = 1'b0;
    endtask

    task automatic drain(input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3, input int n);
        logic [31:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        out_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("drain_pc%0d", i), out_pc_o, exp[i]);
            @(negedge clk_i);
        end
        chk("drain_empty", 32'(out_valid_o), 32'd0);
        out_ready_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; rvfi_valid_i = '0; rvfi_pc_rdata_i = '0; rvfi_insn_i = '0;
        rvfi_rd_addr_i = '0; rvfi_rd_wdata_i = '0; arm_i = 1'b0; cfg_wrap_i = 1'b0;
        cfg_trig_en_i = 1'b0; cfg_trig_pc_i = '0; out_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_pc", out_pc_o, 32'd0);
        chk("rst_dropped", 32'(dropped_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Single-lane streaming with reader always ready
        out_ready_i = 1'b1;
        arm(1'b0, 1'b0, 32'd0);
        chk("t1_state", 32'(state_o), 32'd2);
        retire(2'b01, 32'h100, 32'h0);
        chk("t1_valid", 32'(out_valid_o), 32'd1);
        chk("t1_pc0", out_pc_o, 32'h100);
        chk("t1_insn0", out_insn_o, ~32'h100);
        chk("t1_rd0", 32'(out_rd_addr_o), 32'h0);
        chk("t1_wdata0", out_rd_wdata_o, 32'h5A5A0100);
        retire(2'b01, 32'h104, 32'h0);
        chk("t1_pc1", out_pc_o, 32'h104);
        chk("t1_cnt1", 32'(count_o), 32'd1);
        retire(2'b01, 32'h108, 32'h0);
        chk("t1_pc2", out_pc_o, 32'h108);
        chk("t1_rd2", 32'(out_rd_addr_o), 32'h2);
        @(negedge clk_i);
        chk("t1_cnt_end", 32'(count_o), 32'd0);
        out_ready_i = 1'b0;

        // Two lanes, stop-on-full
        arm(1'b0, 1'b0, 32'd0);
        retire(2'b11, 32'h10, 32'h14);
        retire(2'b11, 32'h18, 32'h1C);
        chk("t2_full_cnt", 32'(count_o), 32'd4);
        chk("t2_full_state", 32'(state_o), 32'd2);
        retire(2'b11, 32'h20, 32'h24);
        chk("t2_cnt", 32'(count_o), 32'd4);
        chk("t2_dropped", 32'(dropped_o), 32'd2);
        chk("t2_state", 32'(state_o), 32'd3);
        retire(2'b10, 32'h0, 32'h28);
        chk("t2_dropped_stopped", 32'(dropped_o), 32'd3);
        drain(32'h10, 32'h14, 32'h18, 32'h1C, 4);
        chk("t2_still_stopped", 32'(state_o), 32'd3);

        // Wrap mode keeps the newest four
        arm(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) retire(2'b01, 32'(4 * i), 32'h0);
        chk("t3_cnt", 32'(count_o), 32'd4);
        chk("t3_ovf", 32'(overflow_o), 32'd1);
        chk("t3_pc", out_pc_o, 32'h8);
        chk("t3_dropped", 32'(dropped_o), 32'd0);
        drain(32'h8, 32'hC, 32'h10, 32'h14, 4);

        // PC trigger
        arm(1'b0, 1'b1, 32'h200);
        chk("t4_armed", 32'(state_o), 32'd1);
        retire(2'b01, 32'h1F0, 32'h0);
        chk("t4_wait_cnt", 32'(count_o), 32'd0);
        chk("t4_ovf_cleared", 32'(overflow_o), 32'd0);
        retire(2'b11, 32'h1FC, 32'h200);
        chk("t4_cnt", 32'(count_o), 32'd1);
        chk("t4_pc", out_pc_o, 32'h200);
        chk("t4_state", 32'(state_o), 32'd2);
        chk("t4_dropped", 32'(dropped_o), 32'd0);
        retire(2'b11, 32'h204, 32'h208);
        chk("t4_cnt_after", 32'(count_o), 32'd3);

        // Pop plus two-lane push with one free slot
        arm(1'b0, 1'b0, 32'd0);
        retire(2'b01, 32'hA0, 32'h0);
        retire(2'b01, 32'hA4, 32'h0);
        retire(2'b01, 32'hA8, 32'h0);
        chk("t5_cnt3", 32'(count_o), 32'd3);
        out_ready_i = 1'b1;
        retire(2'b11, 32'hAC, 32'hB0);
        out_ready_i = 1'b0;
        chk("t5_cnt", 32'(count_o), 32'd3);
        chk("t5_dropped", 32'(dropped_o), 32'd1);
        chk("t5_state", 32'(state_o), 32'd3);
        chk("t5_pc", out_pc_o, 32'hA4);
        drain(32'hA4, 32'hA8, 32'hAC, 32'h0, 3);

        // arm during capture with lanes active: flushed, lanes ignored
        arm(1'b0, 1'b0, 32'd0);
        retire(2'b01, 32'hC0, 32'h0);
        rvfi_valid_i = 2'b11;
        arm(1'b0, 1'b0, 32'd0);
        rvfi_valid_i = 2'b00;
        chk("t5_arm_cnt", 32'(count_o), 32'd0);
        chk("t5_arm_dropped", 32'(dropped_o), 32'd0);
        chk("t5_arm_state", 32'(state_o), 32'd2);

        // Asynchronous reset mid-capture
        arm(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) retire(2'b01, 32'h300 + 32'(4 * i), 32'h0);
        chk("t6_pre_ovf", 32'(overflow_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("t6_state", 32'(state_o), 32'd0);
        chk("t6_cnt", 32'(count_o), 32'd0);
        chk("t6_valid", 32'(out_valid_o), 32'd0);
        chk("t6_ovf", 32'(overflow_o), 32'd0);
        chk("t6_pc", out_pc_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
